// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and status window
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic        o_sel,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_tx_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic is_stat, full, pop, push_req, push, w1c, baud_end;
    logic unused_bits;

    assign o_sel       = i_addr[31:3] == BASE_ADDR[31:3];
    assign is_stat     = i_addr[2];
    assign full        = count_q == (AW+1)'(FIFO_DEPTH);
    assign pop         = state_q == IDLE && count_q != '0;
    assign push_req    = o_sel && !is_stat && i_we;
    assign push        = push_req && (!full || pop);
    assign w1c         = o_sel && is_stat && i_we && i_wdata[3];
    assign baud_end    = baud_q == CW'(CLKS_PER_BIT - 1);
    assign o_tx        = tx_q;
    assign o_tx_empty  = count_q == '0 && state_q == IDLE;
    assign o_rdata     = (o_sel && is_stat)
                       ? {16'h0, 8'(count_q), 4'h0, ovf_q, state_q != IDLE, count_q == '0, full}
                       : 32'h0;
    assign unused_bits = ^{i_addr[1:0], i_wdata[31:8], i_wdata[2:0]};

    // Next-state for FIFO bookkeeping, overflow flag and the serial bit engine
    always_comb begin
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = pop ? rd_q + 1'b1 : rd_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d     = (push_req && !push) ? 1'b1 : (w1c ? 1'b0 : ovf_q);
        state_d   = state_q;
        baud_d    = baud_end ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d   = START;
                    shift_d   = mem_q[rd_q];
                    bit_idx_d = '0;
                end
            end
            START: if (baud_end) state_d = DATA;
            DATA: if (baud_end) begin
                if (bit_idx_q == 3'd7) state_d = STOP;
                else begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: if (baud_end) state_d = IDLE;
        endcase
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    // State registers; reset discards any partial frame and queued bytes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= i_wdata[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus against a frame-timeline model of the UART transmitter
module tb_mmio_uart_tx;
    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = STAT;
    logic [31:0] i_wdata = 32'h0;
    logic        i_we = 1'b0;
    logic        o_sel, o_tx, o_tx_empty;
    logic [31:0] o_rdata;

    int ncmp = 0;
    int nbad = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_reset(rst), .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we),
        .o_sel(o_sel), .o_rdata(o_rdata), .o_tx(o_tx), .o_tx_empty(o_tx_empty)
    );

    always #5 clk = ~clk;

    // Model: queue of accepted bytes plus a position inside the current 10-bit frame
    logic [7:0] mq[$];
    logic       mbusy = 1'b0;
    int         mt = 0;
    logic [7:0] mcur = 8'h0;
    logic       movf = 1'b0;
    logic       m_hit, m_req, m_pop, m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mbusy = 1'b0;
            mt    = 0;
            movf  = 1'b0;
        end else begin
            m_hit = i_addr[31:3] == BASE[31:3];
            m_req = m_hit && !i_addr[2] && i_we;
            m_pop = !mbusy && mq.size() > 0;
            m_acc = m_req && (mq.size() < D || m_pop);
            if (mbusy) begin
                mt++;
                if (mt == 10 * C) mbusy = 1'b0;
            end else if (m_pop) begin
                mcur  = mq.pop_front();
                mbusy = 1'b1;
                mt    = 0;
            end
            if (m_acc) mq.push_back(i_wdata[7:0]);
            if (m_req && !m_acc) movf = 1'b1;
            else if (m_hit && i_addr[2] && i_we && i_wdata[3]) movf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        if (!mbusy) return 1'b1;
        if (mt < C) return 1'b0;
        if (mt < 9 * C) return mcur[(mt - C) / C];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        return {16'h0, 8'(mq.size()), 4'h0, movf, mbusy, mq.size() == 0, mq.size() == D};
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (i_addr[31:3] != BASE[31:3] || !i_addr[2]) return 32'h0;
        return exp_status();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model away from the rising edge
    always @(negedge clk) begin
        chk("m_tx", 32'(o_tx), 32'(exp_tx()));
        chk("m_empty", 32'(o_tx_empty), 32'(mq.size() == 0 && !mbusy));
        chk("m_sel", 32'(o_sel), 32'(i_addr[31:3] == BASE[31:3]));
        chk("m_rdata", o_rdata, exp_rdata());
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we);
        i_addr  = a;
        i_wdata = d;
        i_we    = we;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(STAT, 32'h0, 1'b0);
    endtask

    task automatic peek_status(input string name, input logic [31:0] exp);
        i_we   = 1'b0;
        i_addr = STAT;
        #1;
        chk(name, o_rdata, exp);
    endtask

    task automatic drain(input string name, input int exp);
        int n = 0;
        while (!o_tx_empty && n < 1000) begin
            idle();
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    logic [9:0] frame;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_status", o_rdata, 32'h2);
        chk("reset_tx", 32'(o_tx), 32'h1);
        chk("reset_empty", 32'(o_tx_empty), 32'h1);
        rst = 1'b0;
        idle();

        // single frame 0xA5, start bit first then LSB-first data then stop
        frame = 10'b1_10100101_0;
        cyc(BASE, 32'h0000_00A5, 1'b1);
        chk("t1_tx_before", 32'(o_tx), 32'h1);
        for (int i = 0; i < 10 * C; i++) begin
            idle();
            chk("t1_bit", 32'(o_tx), 32'(frame[i / C]));
        end
        chk("t1_not_empty_40", 32'(o_tx_empty), 32'h0);
        idle();
        chk("t1_empty_41", 32'(o_tx_empty), 32'h1);

        // three back-to-back frames
        cyc(BASE, 32'h31, 1'b1);
        cyc(BASE, 32'h32, 1'b1);
        cyc(BASE, 32'h33, 1'b1);
        chk("t2_count", 32'(o_rdata[15:8]), 32'h0);
        peek_status("t2_status", 32'h0000_0204);
        drain("t2_drain", 121);

        // six writes: the sixth overflows, then W1C clears overflow
        for (int i = 0; i < 6; i++) cyc(BASE, 32'h40 + 32'(i), 1'b1);
        peek_status("t3_status", 32'h0000_040D);
        cyc(STAT, 32'h8, 1'b1);
        peek_status("t4_w1c", 32'h0000_0405);
        drain("t3_drain", 199);
        peek_status("t3_final", 32'h0000_0002);

        // out-of-window stores
        i_addr = BASE + 32'd8;
        #1;
        chk("t5_sel_hi", 32'(o_sel), 32'h0);
        chk("t5_rdata_hi", o_rdata, 32'h0);
        cyc(BASE + 32'd8, 32'hFF, 1'b1);
        i_addr = 32'hFFFE_FFFC;
        #1;
        chk("t5_sel_lo", 32'(o_sel), 32'h0);
        chk("t5_rdata_lo", o_rdata, 32'h0);
        cyc(32'hFFFE_FFFC, 32'hFF, 1'b1);
        idle();
        peek_status("t5_status", 32'h0000_0002);
        chk("t5_tx", 32'(o_tx), 32'h1);

        // reset mid-DATA with two bytes queued
        cyc(BASE, 32'h00, 1'b1);
        cyc(BASE, 32'h11, 1'b1);
        cyc(BASE, 32'h22, 1'b1);
        repeat (6) idle();
        chk("t6_tx_low", 32'(o_tx), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tx_async", 32'(o_tx), 32'h1);
        peek_status("t6_status_rst", 32'h0000_0002);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (100) idle();
        peek_status("t6_status_after", 32'h0000_0002);
        chk("t6_empty_after", 32'(o_tx_empty), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
